hpdcache_fifo_reg_init_count: RTL and testbench

//  Register-based FIFO whose contents and fill level are preloaded at reset and on flush.
//  - INIT_COUNT entries are valid after init, taken from initial_value_i[0..INIT_COUNT-1].
//  - Exposes occupancy and an almost-full flag.
//  - Used for free-lists and credit pools (MSHR ids, refill buffer slots) that start partially or fully populated.

---
 rtl/hpdcache_fifo_pkg.sv | 35 +++
 rtl/hpdcache_fifo_reg_init_count_chk.sv | 34 +++
 rtl/hpdcache_fifo_wrap_ptr.sv | 45 ++++
 rtl/hpdcache_fifo_reg_init_count.sv | 160 ++++++++++++++++
 tb/tb_hpdcache_fifo_reg_init_count.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/hpdcache_fifo_pkg.sv
// Shared helpers for the hpdcache register FIFOs: pointer/counter widths and
// the per-cycle storage operation encoding.
package hpdcache_fifo_pkg;

    localparam int unsigned FIFO_MIN_PTR_W = 32'd1;

    // Storage operation applied in one cycle: {push, pop}
    typedef enum logic [1:0] {
        FIFO_OP_IDLE = 2'b00,
        FIFO_OP_POP  = 2'b01,
        FIFO_OP_PUSH = 2'b10,
        FIFO_OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int unsigned fifo_ptr_width(input int unsigned depth);
        if (depth > 32'd1) begin
            return $clog2(depth);
        end else begin
            return FIFO_MIN_PTR_W;
        end
    endfunction

    function automatic int unsigned fifo_cnt_width(input int unsigned depth);
        if (depth > 32'd0) begin
            return $clog2(depth + 32'd1);
        end else begin
            return 32'd1;
        end
    endfunction

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/hpdcache_fifo_reg_init_count_chk.sv
// Invariant checker for hpdcache_fifo_reg_init_count: occupancy bound and
// pointer distance consistency with the occupancy counter.
module hpdcache_fifo_reg_init_count_chk
#(
    parameter int unsigned FIFO_DEPTH = 32'd4,
    parameter int unsigned PTR_W      = 32'd2,
    parameter int unsigned CNT_W      = 32'd3
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [PTR_W-1:0] rptr_i,
    input  logic [PTR_W-1:0] wptr_i,
    input  logic [CNT_W-1:0] usage_i
);

    int unsigned ptr_dist_s;
    int unsigned usage_mod_s;

    // Distance between write and read pointers modulo the depth
    always_comb begin
        ptr_dist_s  = (32'(wptr_i) + FIFO_DEPTH - 32'(rptr_i)) % FIFO_DEPTH;
        usage_mod_s = 32'(usage_i) % FIFO_DEPTH;
    end

    usage_bound_a: assert property (@(posedge clk_i) disable iff (rst_i)
        32'(usage_i) <= FIFO_DEPTH)
        else $error("usage above depth");

    ptr_dist_a: assert property (@(posedge clk_i) disable iff (rst_i)
        ptr_dist_s == usage_mod_s)
        else $error("pointer distance disagrees with usage");

endmodule

// File: rtl/hpdcache_fifo_wrap_ptr.sv
// Loadable wrapping pointer: counts 0..MAX then returns to 0, so any depth
// (not only powers of two) is supported.
module hpdcache_fifo_wrap_ptr
#(
    parameter int unsigned MAX   = 32'd3,
    parameter int unsigned PTR_W = 32'd2
)
(
    input  logic             clk_i,
    input  logic             inc_i,
    input  logic             load_i,
    input  logic [PTR_W-1:0] load_val_i,
    output logic [PTR_W-1:0] ptr_o
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next pointer: load wins over increment, increment wraps at MAX
    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_val_i;
        end else if (inc_i) begin
            if (ptr_q == PTR_LAST) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PTR_ONE;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk_i) begin
        ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/hpdcache_fifo_reg_init_count.sv
// Register FIFO preloaded with INIT_COUNT entries on reset/flush.
// Optional HPDCACHE_FIFO_INIT_BYPASS_EN: empty-FIFO write is visible same cycle.
// HPDCACHE_ASSERT_OFF removes the invariant checker.
module hpdcache_fifo_reg_init_count
    import hpdcache_fifo_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 32'd4,
    parameter int unsigned INIT_COUNT   = FIFO_DEPTH,
    parameter int unsigned AFULL_THRESH = FIFO_DEPTH - 32'd1,
    parameter type         fifo_data_t  = logic,
    localparam int unsigned PTR_W       = fifo_ptr_width(FIFO_DEPTH),
    localparam int unsigned CNT_W       = fifo_cnt_width(FIFO_DEPTH)
)
(
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            w_i,
    output logic                            wok_o,
    input  fifo_data_t                      wdata_i,
    input  logic                            r_i,
    output logic                            rok_o,
    output fifo_data_t                      rdata_o,
    input  fifo_data_t [FIFO_DEPTH-1:0]     initial_value_i,
    output logic [CNT_W-1:0]                usage_o,
    output logic                            almost_full_o
);

    if (FIFO_DEPTH == 32'd0) begin : gen_err_depth
        $error("FIFO_DEPTH must be at least 1");
    end
    if (INIT_COUNT > FIFO_DEPTH) begin : gen_err_init
        $error("INIT_COUNT must not exceed FIFO_DEPTH");
    end
    if ((AFULL_THRESH == 32'd0) || (AFULL_THRESH > FIFO_DEPTH)) begin : gen_err_afull
        $error("AFULL_THRESH must be in 1..FIFO_DEPTH");
    end

    localparam int unsigned SAFE_DEPTH = (FIFO_DEPTH == 32'd0) ? 32'd1 : FIFO_DEPTH;
    localparam logic [PTR_W-1:0] WPTR_INIT  = PTR_W'(INIT_COUNT % SAFE_DEPTH);
    localparam logic [PTR_W-1:0] RPTR_INIT  = PTR_W'(0);
    localparam logic [CNT_W-1:0] USAGE_INIT = CNT_W'(INIT_COUNT);
    localparam logic [CNT_W-1:0] USAGE_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] USAGE_AF   = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] USAGE_ONE  = CNT_W'(1);

    fifo_data_t [FIFO_DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]            rptr_q;
    logic [PTR_W-1:0]            wptr_q;
    logic [CNT_W-1:0]            usage_q;
    logic [CNT_W-1:0]            usage_d;
    logic                        rok_q;
    logic                        wok_q;
    logic                        afull_q;

    logic init_s;
    logic byp_s;
    logic consume_s;
    logic push_s;
    logic pop_s;

    assign init_s = rst_i | flush_i;

`ifdef HPDCACHE_FIFO_INIT_BYPASS_EN
    // Empty FIFO with a write presents the write data directly at the head
    assign byp_s     = ~rok_q & w_i;
    assign consume_s = byp_s & r_i;
`else
    assign byp_s     = 1'b0;
    assign consume_s = 1'b0;
`endif

    // A bypass-consumed entry never touches storage, pointers or usage
    assign push_s = w_i & wok_q & ~consume_s & ~init_s;
    assign pop_s  = r_i & rok_q & ~init_s;

    // Occupancy next state
    always_comb begin
        usage_d = usage_q;
        if (init_s) begin
            usage_d = USAGE_INIT;
        end else begin
            case (fifo_op(push_s, pop_s))
                FIFO_OP_PUSH: usage_d = usage_q + USAGE_ONE;
                FIFO_OP_POP:  usage_d = usage_q - USAGE_ONE;
                FIFO_OP_BOTH: usage_d = usage_q;
                FIFO_OP_IDLE: usage_d = usage_q;
                default:      usage_d = usage_q;
            endcase
        end
    end

    // Occupancy and handshake flags, all derived from next occupancy
    always_ff @(posedge clk_i) begin
        usage_q <= usage_d;
        rok_q   <= (usage_d != '0);
        wok_q   <= (usage_d != USAGE_FULL);
        afull_q <= (usage_d >= USAGE_AF);
    end

    // Storage: preload on init, otherwise write at the tail
    always_ff @(posedge clk_i) begin
        if (init_s) begin
            mem_q <= initial_value_i;
        end else if (push_s) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    hpdcache_fifo_wrap_ptr #(
        .MAX   (SAFE_DEPTH - 32'd1),
        .PTR_W (PTR_W)
    ) i_rptr (
        .clk_i      (clk_i),
        .inc_i      (pop_s),
        .load_i     (init_s),
        .load_val_i (RPTR_INIT),
        .ptr_o      (rptr_q)
    );

    hpdcache_fifo_wrap_ptr #(
        .MAX   (SAFE_DEPTH - 32'd1),
        .PTR_W (PTR_W)
    ) i_wptr (
        .clk_i      (clk_i),
        .inc_i      (push_s),
        .load_i     (init_s),
        .load_val_i (WPTR_INIT),
        .ptr_o      (wptr_q)
    );

    // Head data, overridden by the write data while bypassing
    always_comb begin
        if (byp_s) begin
            rdata_o = wdata_i;
        end else begin
            rdata_o = mem_q[rptr_q];
        end
    end

    assign rok_o         = rok_q | byp_s;
    assign wok_o         = wok_q;
    assign usage_o       = usage_q;
    assign almost_full_o = afull_q;

`ifndef HPDCACHE_ASSERT_OFF
    hpdcache_fifo_reg_init_count_chk #(
        .FIFO_DEPTH (SAFE_DEPTH),
        .PTR_W      (PTR_W),
        .CNT_W      (CNT_W)
    ) i_chk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .rptr_i  (rptr_q),
        .wptr_i  (wptr_q),
        .usage_i (usage_q)
    );
`endif

endmodule

// File: tb/tb_hpdcache_fifo_reg_init_count.sv
// Scoreboard bench: a DEPTH=4/INIT=4 FIFO and a DEPTH=3/INIT=1 FIFO,
// each checked against a queue model every cycle.
module tb_hpdcache_fifo_reg_init_count;

`ifdef HPDCACHE_FIFO_INIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       w_s     [2];
    logic       r_s     [2];
    logic       flush_s [2];
    logic [7:0] wd_s    [2];
    logic       wok_s   [2];
    logic       rok_s   [2];
    logic       afull_s [2];
    logic [7:0] rdata_s [2];
    logic [2:0] usage_s [2];

    logic       wok_a, rok_a, afull_a, wok_b, rok_b, afull_b;
    logic [7:0] rdata_a, rdata_b;
    logic [2:0] usage_a;
    logic [1:0] usage_b;
    logic [3:0][7:0] init_a;
    logic [2:0][7:0] init_b;

    hpdcache_fifo_reg_init_count #(
        .FIFO_DEPTH(4), .INIT_COUNT(4), .AFULL_THRESH(3), .fifo_data_t(logic [7:0])
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_s[0]), .w_i(w_s[0]), .wok_o(wok_a),
        .wdata_i(wd_s[0]), .r_i(r_s[0]), .rok_o(rok_a), .rdata_o(rdata_a),
        .initial_value_i(init_a), .usage_o(usage_a), .almost_full_o(afull_a)
    );

    hpdcache_fifo_reg_init_count #(
        .FIFO_DEPTH(3), .INIT_COUNT(1), .AFULL_THRESH(2), .fifo_data_t(logic [7:0])
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_s[1]), .w_i(w_s[1]), .wok_o(wok_b),
        .wdata_i(wd_s[1]), .r_i(r_s[1]), .rok_o(rok_b), .rdata_o(rdata_b),
        .initial_value_i(init_b), .usage_o(usage_b), .almost_full_o(afull_b)
    );

    always_comb begin
        wok_s[0]   = wok_a;   wok_s[1]   = wok_b;
        rok_s[0]   = rok_a;   rok_s[1]   = rok_b;
        afull_s[0] = afull_a; afull_s[1] = afull_b;
        rdata_s[0] = rdata_a; rdata_s[1] = rdata_b;
        usage_s[0] = usage_a; usage_s[1] = {1'b0, usage_b};
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] mq [2][$];

    function automatic int depth_of(input int sel);
        return (sel == 0) ? 4 : 3;
    endfunction

    function automatic int init_of(input int sel);
        return (sel == 0) ? 4 : 1;
    endfunction

    function automatic int thr_of(input int sel);
        return (sel == 0) ? 3 : 2;
    endfunction

    task automatic check_val(input string tag, input int sel,
                             input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h exp=%0h at %0t", tag, sel, got, exp, $time);
        end
    endtask

    task automatic load_model(input int sel);
        mq[sel].delete();
        for (int i = 0; i < init_of(sel); i++) begin
            mq[sel].push_back((sel == 0) ? init_a[i] : init_b[i]);
        end
    endtask

    // One cycle of stimulus on FIFO sel, checking outputs and updating the model
    task automatic step(input int sel, input logic w, input logic r, input logic [7:0] wd);
        int sz;
        bit emp, full;
        logic [7:0] e;
        sz   = mq[sel].size();
        emp  = (sz == 0);
        full = (sz == depth_of(sel));
        w_s[sel] = w; r_s[sel] = r; wd_s[sel] = wd;
        #1;
        check_val("usage", sel, 32'(usage_s[sel]), 32'(sz));
        check_val("wok", sel, 32'(wok_s[sel]), 32'(!full));
        check_val("afull", sel, 32'(afull_s[sel]), 32'(sz >= thr_of(sel)));
        check_val("rok", sel, 32'(rok_s[sel]), 32'(!emp || (BYP && w)));
        if (!emp) begin
            check_val("rdata", sel, 32'(rdata_s[sel]), 32'(mq[sel][0]));
        end else if (BYP && w) begin
            check_val("byp_rdata", sel, 32'(rdata_s[sel]), 32'(wd));
        end
        if (!(emp && BYP && w && r)) begin
            if (r && !emp) e = mq[sel].pop_front();
            if (w && !full) mq[sel].push_back(wd);
        end
        @(posedge clk); #1;
        w_s[sel] = 1'b0; r_s[sel] = 1'b0;
    endtask

    // Flush with a simultaneous read and write request that must be ignored
    task automatic flush_fifo(input int sel);
        flush_s[sel] = 1'b1; w_s[sel] = 1'b1; r_s[sel] = 1'b1;
        wd_s[sel] = 8'($urandom);
        @(posedge clk); #1;
        flush_s[sel] = 1'b0; w_s[sel] = 1'b0; r_s[sel] = 1'b0;
        load_model(sel);
        check_val("flush_usage", sel, 32'(usage_s[sel]), 32'(init_of(sel)));
        check_val("flush_rdata", sel, 32'(rdata_s[sel]),
                  32'((sel == 0) ? init_a[0] : init_b[0]));
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            w_s[s] = 1'b0; r_s[s] = 1'b0; flush_s[s] = 1'b0; wd_s[s] = 8'h00;
        end
        init_a = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        init_b = {8'h33, 8'h22, 8'h11};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        load_model(0);
        load_model(1);

        check_val("rst_usage", 0, 32'(usage_a), 32'd4);
        check_val("rst_rok", 0, 32'(rok_a), 32'd1);
        check_val("rst_wok", 0, 32'(wok_a), 32'd0);
        check_val("rst_rdata", 0, 32'(rdata_a), 32'h0000_00AA);
        check_val("rst_usage", 1, 32'(usage_b), 32'd1);
        check_val("rst_wok", 1, 32'(wok_b), 32'd1);
        check_val("rst_afull", 1, 32'(afull_b), 32'd0);

        // Drain the preloaded FIFO
        for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b1, 8'h00);
        step(0, 1'b0, 1'b0, 8'h00);

        // Fill the depth-3 FIFO and read through the wrap point
        step(1, 1'b1, 1'b0, 8'h58);
        step(1, 1'b1, 1'b0, 8'h59);
        step(1, 1'b1, 1'b1, 8'h60);
        for (int i = 0; i < 4; i++) step(1, 1'b0, 1'b1, 8'h00);

        // Full with simultaneous read/write, then a plain write
        for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 8'(8'hE0 + i));
        step(0, 1'b1, 1'b1, 8'hEE);
        step(0, 1'b1, 1'b0, 8'hEF);
        step(0, 1'b0, 1'b1, 8'h00);

        // Flush mid-stream with fresh preload values
        init_a = {8'h44, 8'h43, 8'h42, 8'h41};
        flush_fifo(0);
        step(0, 1'b0, 1'b0, 8'h00);

        // Empty with simultaneous read/write
        for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b1, 8'h00);
        step(0, 1'b1, 1'b1, 8'h5A);
        step(0, 1'b0, 1'b0, 8'h00);

        // Random traffic with occasional flushes
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 199) == 0) begin
                    if (s == 0) init_a = {$urandom()};
                    else init_b = 24'($urandom());
                    flush_fifo(s);
                end else begin
                    step(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
